// File: rtl/branch_pkg.sv
// Purpose: shared constants and types for the fetch-side branch redirect block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: AArch64 branch opcode constants, immediate field widths, the
// redirect FSM state type and the sequential PC increment.
package branch_pkg;

  // Unconditional B: opcode lives in [31:26].
  localparam logic [5:0] OP_B     = 6'b000101;
  // B.cond and CBZ: opcode lives in [31:24].
  localparam logic [7:0] OP_BCOND = 8'h54;
  localparam logic [7:0] OP_CBZ   = 8'hB4;

  localparam int IMM26_W = 26;
  localparam int IMM19_W = 19;

  localparam int PC_INC = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } redir_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Purpose: decode branch class and compute the PC-relative branch target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: instruction/branch_pc in; target (branch_pc + imm*4, wraps) and
//        is_branch (instruction is B, B.cond or CBZ) out.
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic [ADDR_W-1:0] target,
  output logic              is_branch
);

  logic [ADDR_W-1:0] imm;

  always_comb begin
    imm       = '0;
    is_branch = 1'b0;
    if (instruction[31:26] == OP_B) begin
      imm       = {{(ADDR_W-IMM26_W){instruction[25]}}, instruction[25:0]};
      is_branch = 1'b1;
    end else if ((instruction[31:24] == OP_BCOND) || (instruction[31:24] == OP_CBZ)) begin
      imm       = {{(ADDR_W-IMM19_W){instruction[23]}}, instruction[23:5]};
      is_branch = 1'b1;
    end
    // Word offset to byte offset; the add wraps modulo 2^ADDR_W by width.
    target = branch_pc + {imm[ADDR_W-3:0], 2'b00};
  end

endmodule

// File: rtl/branch_redirect.sv
// Purpose: owns the fetch PC; redirects to taken-branch targets and flushes the wrong path.
// Latency: taken decision sampled at edge N -> pc=target, redirect=1 after edge N.
// Backpressure: stall freezes pc (and the flush countdown); a take overrides stall.
// Ports: clk, reset (async active-low), br_valid/branchInstruction/branchPC/BrTaken
//        from reg/dec, stall from hazard logic; pc/flush/redirect registered outputs.
//        With BRANCH_REDIRECT_STATS_EN defined, adds saturating taken_cnt and flush_cnt.
module branch_redirect
  import branch_pkg::*;
#(
  parameter int                ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [31:0]       branchInstruction,
  input  logic [ADDR_W-1:0] branchPC,
  input  logic              BrTaken,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
`ifdef BRANCH_REDIRECT_STATS_EN
  output logic              redirect,
  output logic [31:0]       taken_cnt,
  output logic [31:0]       flush_cnt
`else
  output logic              redirect
`endif
);

  // Countdown loaded on redirect; flush drops once it has run out.
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  redir_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              redirect_q, redirect_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] target;
  logic              is_branch;
  logic              take;
  logic [ADDR_W-1:0] pc_inc;

  branch_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .instruction (branchInstruction),
    .branch_pc   (branchPC),
    .target      (target),
    .is_branch   (is_branch)
  );

  // Only branch-class opcodes redirect; the instruction in reg/dec during
  // FLUSH is on the wrong path, so its decision is discarded.
  assign take   = br_valid & BrTaken & (state_q == RUN) & is_branch;
  assign pc_inc = pc_q + ADDR_W'(PC_INC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    redirect_d = 1'b0;
    cnt_d      = cnt_q;
    if (state_q == RUN) begin
      if (take) begin
        pc_d       = target;
        redirect_d = 1'b1;
        flush_d    = 1'b1;
        cnt_d      = CNT_INIT;
        state_d    = FLUSH;
      end else begin
        flush_d = 1'b0;
        if (!stall) begin
          pc_d = pc_inc;
        end
      end
    end else begin
      // Stall freezes pc, countdown and flush together.
      if (!stall) begin
        pc_d = pc_inc;
        if (cnt_q != 3'd0) begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end else begin
          flush_d = 1'b0;
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign redirect = redirect_q;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (take && (taken_cnt_q != 32'hFFFF_FFFF)) begin
      taken_cnt_d = taken_cnt_q + 32'd1;
    end
    if (flush_q && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/branch_redirect.md
Name: branch_redirect

Overview:
- Fetch-side consumer of the branch-taken decision: owns the PC register, computes branch targets and steers fetch.
- Sequences the wrong-path flush after a taken branch.
- Sits between the branch-resolution logic in reg/dec (which supplies BrTaken with the branch instruction and its PC) and the instruction-memory address port.
- Replaces the ad-hoc PC mux with a registered, FSM-controlled redirect.

Parameters:
ADDR_W, 64, PC / address width in bits
RESET_PC, 64'h0, PC value loaded on reset
FLUSH_CYCLES, 1, cycles flush is held after a redirect (1..7)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
br_valid  input  1  a branch-class instruction is in reg/dec this cycle
branchInstruction  input  32  instruction word held in reg/dec
branchPC  input  ADDR_W  PC of branchInstruction
BrTaken  input  1  branch-taken decision for branchInstruction
stall  input  1  hazard stall; freeze sequential fetch
pc  output  ADDR_W  current fetch address (registered)
flush  output  1  kill the instruction currently in IF/ID (registered)
redirect  output  1  one-cycle pulse: pc was just loaded with a branch target

Behaviour:
- Reset (async, reset==0): pc=RESET_PC, flush=0, redirect=0, cnt=0, state=RUN. Takes effect immediately, including mid-FLUSH. Deassertion is synchronous to clk via normal flop release.
- Target calc (combinational):
  - opcode [31:26]==6'b000101 (B): imm=sext([25:0]).
  - [31:24]==8'h54 (B.cond) or 8'hB4 (CBZ): imm=sext([23:5]).
  - target = branchPC + (imm<<2), modulo 2^ADDR_W; no overflow detection.
- take = br_valid & BrTaken & state==RUN & opcode in {B, B.cond, CBZ}. BrTaken with any other opcode is ignored (fall-through).
- State RUN:
  - take: next pc=target, redirect<=1, flush<=1, cnt<=FLUSH_CYCLES-1, state<=FLUSH. take overrides stall.
  - else if stall: pc holds, flush<=0, redirect<=0.
  - else: pc<=pc+4 (wraps at 2^ADDR_W), flush<=0, redirect<=0.
- State FLUSH:
  - redirect<=0.
  - pc<=pc+4 unless stall, which holds both pc and cnt.
  - br_valid/BrTaken ignored (wrong-path instruction).
  - cnt!=0: cnt decrements, flush stays 1.
  - cnt==0 (and no stall): flush<=0, state<=RUN.
- Latency: BrTaken sampled at edge N; pc==target and redirect==1 visible after edge N; flush high for exactly FLUSH_CYCLES cycles when no stall intervenes.
- redirect is never high two consecutive cycles. Back-to-back taken branches cannot redirect during FLUSH.

Optional Feature:
BRANCH_REDIRECT_STATS_EN
- Defined: adds outputs taken_cnt[31:0] (increments on each take) and flush_cnt[31:0] (increments each cycle flush==1). Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package branch_pkg:
  - opcode constants OP_B=6'b000101, OP_BCOND=8'h54, OP_CBZ=8'hB4
  - imm field widths 26/19
  - typedef enum logic {RUN, FLUSH} redir_state_t
  - PC_INC=4
- Sub-module branch_target_calc (combinational: instruction, branchPC -> target, is_branch). Reused by the verification reference model.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=3): assert reset low at flush cycle 2 -> pc=RESET_PC, flush=0 immediately; after release, pc 0,4,8 sequential.
- B forward: branchPC=0x100, instr=0x14000010, BrTaken=1 -> next pc=0x140, redirect pulse 1 cycle, flush 1 cycle, then pc 0x144.
- CBZ backward: branchPC=0x200, imm19=-4 (instr=0xB4FFFF80|Rt), BrTaken=1 -> pc=0x1F0; BrTaken=0 -> pc continues +4.
- Stall during FLUSH (FLUSH_CYCLES=2): stall 1 cycle after redirect -> pc and flush held, flush total 3 cycles; then state RUN.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, no branch -> pc=0x0. B with imm26=-1 at branchPC=0 -> target 0xFFFF_FFFF_FFFF_FFFC.
- Ignored cases: BrTaken=1 with opcode ADD (0x8B...) -> no redirect. Taken branch during FLUSH -> ignored, pc sequential.
